// File: rtl/alu_pkg.sv
// Shared definitions for the execute stage: ALU op codes, FSM/shift encodings,
// and the RV32I instruction-format constants the ALU decoder also uses.
package alu_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OP_ADD    = 5'h00;
    localparam logic [OP_W-1:0] OP_SUB    = 5'h01;
    localparam logic [OP_W-1:0] OP_AND    = 5'h02;
    localparam logic [OP_W-1:0] OP_OR     = 5'h03;
    localparam logic [OP_W-1:0] OP_XOR    = 5'h04;
    localparam logic [OP_W-1:0] OP_SLL    = 5'h05;
    localparam logic [OP_W-1:0] OP_SRL    = 5'h06;
    localparam logic [OP_W-1:0] OP_SLT    = 5'h07;
    localparam logic [OP_W-1:0] OP_SRA    = 5'h0E;
    localparam logic [OP_W-1:0] OP_SLTU   = 5'h0F;
    localparam logic [OP_W-1:0] OP_SLL_12 = 5'h10;

    localparam int LUI_SHAMT = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        SH_LEFT,
        SH_RIGHT_LOG,
        SH_RIGHT_ARITH
    } shift_kind_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    function automatic logic is_shift_op(input logic [OP_W-1:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    function automatic shift_kind_e shift_kind(input logic [OP_W-1:0] op);
        case (op)
            OP_SRL:  return SH_RIGHT_LOG;
            OP_SRA:  return SH_RIGHT_ARITH;
            default: return SH_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/alu_exec_comb.sv
// Single-cycle ALU datapath: arithmetic, logic, compares, the LUI path and
// illegal-op detection. Shift ops are legal here but produced by the top.
module alu_comb
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    logic lt_signed;
    logic lt_unsigned;

    assign lt_signed   = $signed(a) < $signed(b);
    assign lt_unsigned = a < b;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (op)
            OP_ADD:    result = a + b;
            OP_SUB:    result = a - b;
            OP_AND:    result = a & b;
            OP_OR:     result = a | b;
            OP_XOR:    result = a ^ b;
            OP_SLT:    result = {{(XLEN-1){1'b0}}, lt_signed};
            OP_SLTU:   result = {{(XLEN-1){1'b0}}, lt_unsigned};
            OP_SLL_12: result = b << LUI_SHAMT;
            OP_SLL, OP_SRL, OP_SRA: result = '0;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// Multi-cycle execute unit: single-cycle ALU ops plus an iterative
// 1-bit-per-cycle shifter, behind valid/ready handshakes on both sides.
module alu_exec
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            err
);

    state_e      state_q, state_d;
    shift_kind_e kind_q, kind_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            err_q, err_d;

    logic [XLEN-1:0] comb_result;
    logic            comb_illegal;
    logic [XLEN-1:0] acc_shifted;

    alu_comb #(.XLEN(XLEN)) u_comb (
        .op      (op),
        .a       (a),
        .b       (b),
        .result  (comb_result),
        .illegal (comb_illegal)
    );

    always_comb begin
        acc_shifted = '0;
        case (kind_q)
            SH_RIGHT_LOG:   acc_shifted = {1'b0, acc_q[XLEN-1:1]};
            SH_RIGHT_ARITH: acc_shifted = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
            default:        acc_shifted = {acc_q[XLEN-2:0], 1'b0};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_shift_op(op)) begin
                        acc_d  = a;
                        cnt_d  = b[SHW-1:0];
                        kind_d = shift_kind(op);
                        if (b[SHW-1:0] == '0) begin
                            result_d = a;
                            zero_d   = (a == '0);
                            err_d    = 1'b0;
                            state_d  = ST_DONE;
                        end else begin
                            state_d  = ST_SHIFT;
                        end
                    end else begin
                        result_d = comb_result;
                        zero_d   = (comb_result == '0);
                        err_d    = comb_illegal;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                acc_d = acc_shifted;
                cnt_d = cnt_q - SHW'(1);
                // Last step: the shifted value goes straight into the result register.
                if (cnt_q == SHW'(1)) begin
                    result_d = acc_shifted;
                    zero_d   = (acc_shifted == '0);
                    err_d    = 1'b0;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            kind_q   <= SH_LEFT;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed vectors, randomized ops against a
// behavioural model, backpressure, and reset in the middle of a shift.
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        err;

    int checks   = 0;
    int failures = 0;

    alu_exec #(.XLEN(32), .SHW(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic bit is_shift(input logic [4:0] o);
        return (o == 5'h05) || (o == 5'h06) || (o == 5'h0E);
    endfunction

    function automatic bit is_legal(input logic [4:0] o);
        return (o <= 5'h07) || (o == 5'h0E) || (o == 5'h0F) || (o == 5'h10);
    endfunction

    // Reference: {err, result} straight from the op definitions.
    function automatic logic [32:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        int unsigned sh;
        logic [31:0] r;
        sx = x;
        sy = y;
        sh = y % 32;
        r  = 32'h0;
        case (o)
            5'h00: r = x + y;
            5'h01: r = x - y;
            5'h02: r = x & y;
            5'h03: r = x | y;
            5'h04: r = x ^ y;
            5'h05: r = x << sh;
            5'h06: r = x >> sh;
            5'h07: r = (sx < sy) ? 32'd1 : 32'd0;
            5'h0E: r = sx >>> sh;
            5'h0F: r = (x < y) ? 32'd1 : 32'd0;
            5'h10: r = y * 32'd4096;
            default: return {1'b1, 32'h0};
        endcase
        return {1'b0, r};
    endfunction

    task automatic fail_val(input string name, input logic [31:0] got, input logic [31:0] want);
        failures++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, want);
    endtask

    task automatic run_op(input string name, input logic [4:0] f_op, input logic [31:0] f_a,
                          input logic [31:0] f_b, input int stall,
                          input logic [31:0] exp_res, input logic exp_err);
        int lat;
        int exp_lat;
        bit seen;
        bit ready_dropped;
        bit stable_ok;
        logic [31:0] got;
        exp_lat = is_shift(f_op) ? 1 + int'(f_b % 32) : 1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) fail_val({name, " in_ready_before"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op = f_op;
        a  = f_a;
        b  = f_b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 5'($urandom);
        a  = $urandom;
        b  = $urandom;
        lat = 0;
        seen = 1'b0;
        ready_dropped = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 1) ready_dropped = (in_ready === 1'b0);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!ready_dropped) fail_val({name, " in_ready_after_fire"}, 32'(in_ready), 32'd0);
        checks++;
        if (!seen) begin
            fail_val({name, " timeout"}, 32'(lat), 32'(exp_lat));
        end else begin
            checks++;
            if (lat !== exp_lat) fail_val({name, " latency"}, 32'(lat), 32'(exp_lat));
            got = result;
            checks++;
            if (result !== exp_res) fail_val({name, " result"}, result, exp_res);
            checks++;
            if (zero !== (exp_res == 32'h0)) fail_val({name, " zero"}, 32'(zero), 32'(exp_res == 32'h0));
            checks++;
            if (err !== exp_err) fail_val({name, " err"}, 32'(err), 32'(exp_err));
            stable_ok = 1'b1;
            repeat (stall) begin
                @(negedge clk);
                if (out_valid !== 1'b1 || result !== got || in_ready !== 1'b0) stable_ok = 1'b0;
            end
            if (stall > 0) begin
                checks++;
                if (!stable_ok) fail_val({name, " hold_stable"}, result, got);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0)
                fail_val({name, " ready_after_consume"}, {30'h0, in_ready, out_valid}, 32'h2);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = 5'h0;
        a = 32'h0;
        b = 32'h0;
        #12;
        checks++;
        if ({out_valid, zero, err} !== 3'b000) fail_val("reset flags", {29'h0, out_valid, zero, err}, 32'h0);
        checks++;
        if (result !== 32'h0) fail_val("reset result", result, 32'h0);
        checks++;
        if (in_ready !== 1'b1) fail_val("reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        run_op("add",      5'h00, 32'd5,          32'd7,          0, 32'd12,         1'b0);
        run_op("sub",      5'h01, 32'd3,          32'd5,          0, 32'hFFFFFFFE,   1'b0);
        run_op("slt",      5'h07, 32'hFFFFFFFF,   32'd1,          0, 32'd1,          1'b0);
        run_op("sltu",     5'h0F, 32'hFFFFFFFF,   32'd1,          0, 32'd0,          1'b0);
        run_op("sub_zero", 5'h01, 32'h1234,       32'h1234,       0, 32'h0,          1'b0);
        run_op("sra",      5'h0E, 32'h80000000,   32'd4,          0, 32'hF8000000,   1'b0);
        run_op("srl",      5'h06, 32'h80000000,   32'd4,          0, 32'h08000000,   1'b0);
        run_op("sll0",     5'h05, 32'hDEADBEEF,   32'd0,          0, 32'hDEADBEEF,   1'b0);
        run_op("sll31",    5'h05, 32'd1,          32'd31,         0, 32'h80000000,   1'b0);
        run_op("sll_12",   5'h10, 32'h12345678,   32'h000ABCDE,   0, 32'hABCDE000,   1'b0);
        run_op("illegal",  5'h08, 32'h11111111,   32'h22222222,   0, 32'h0,          1'b1);
        run_op("and",      5'h02, 32'hF0F0FF00,   32'h0FF0F0F0,   2, 32'h00F0F000,   1'b0);
        run_op("or",       5'h03, 32'hF0000001,   32'h0000000E,   0, 32'hF000000F,   1'b0);
        run_op("xor",      5'h04, 32'hAAAA5555,   32'hFFFF0000,   0, 32'h55555555,   1'b0);
    endtask

    task automatic test_random();
        logic [4:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        logic [32:0] exp;
        logic [4:0]  legal_ops [11] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05,
                                        5'h06, 5'h07, 5'h0E, 5'h0F, 5'h10};
        for (int i = 0; i < 60; i++) begin
            int pick;
            pick = int'($urandom_range(0, 11));
            if (pick < 11) begin
                r_op = legal_ops[pick];
            end else begin
                r_op = 5'($urandom);
                while (is_legal(r_op)) r_op = 5'($urandom);
            end
            r_a = $urandom;
            r_b = ($urandom_range(0, 3) == 0) ? r_a : $urandom;
            exp = model(r_op, r_a, r_b);
            run_op($sformatf("rand%0d_op%02h", i, r_op), r_op, r_a, r_b,
                   int'($urandom_range(0, 3)), exp[31:0], exp[32]);
        end
    endtask

    task automatic test_backpressure();
        bit hold_ok;
        @(negedge clk);
        in_valid = 1'b1;
        op = 5'h00;
        a = 32'd100;
        b = 32'd23;
        @(posedge clk);
        #1;
        op = 5'h01;
        a = 32'd50;
        b = 32'd8;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd123) fail_val("bp first result", result, 32'd123);
        hold_ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || result !== 32'd123 || in_ready !== 1'b0 || zero !== 1'b0) hold_ok = 1'b0;
        end
        checks++;
        if (!hold_ok) fail_val("bp hold", result, 32'd123);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            fail_val("bp consume no_accept", {30'h0, in_ready, out_valid}, 32'h2);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd42) fail_val("bp held request", result, 32'd42);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        bit idle_ok;
        @(negedge clk);
        in_valid = 1'b1;
        op = 5'h05;
        a = 32'h0000_00F3;
        b = 32'd20;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0)
            fail_val("mid_shift busy", {30'h0, in_ready, out_valid}, 32'h0);
        reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, zero, err} !== 3'b000 || result !== 32'h0)
            fail_val("mid_shift reset outputs", result, 32'h0);
        checks++;
        if (in_ready !== 1'b1) fail_val("mid_shift reset idle", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        idle_ok = 1'b1;
        repeat (25) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) idle_ok = 1'b0;
        end
        checks++;
        if (!idle_ok) fail_val("mid_shift discarded", 32'(out_valid), 32'd0);
        run_op("add_after_reset", 5'h00, 32'h7FFFFFFF, 32'd1, 0, 32'h80000000, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_shift();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_exec.md
# alu_exec

Multi-cycle execute unit for the RISC-V core. It consumes the 5-bit ALU operation code produced by the ALU decoder, plus two operands, over a valid/ready handshake, and returns a registered result with zero and error flags. Single-cycle ops complete in one cycle. Shifts use an iterative 1-bit-per-cycle shifter to save area. It sits between operand fetch/immediate select and writeback/branch logic.

## Interface
- `XLEN`, default 32: operand/result width.
- `SHW`, default 5: shift-amount width, equal to log2(XLEN).
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operation request.
- `in_ready` out 1: unit can accept a request.
- `op` in 5: ALU op code.
- `a` in XLEN: operand A (rs1 / PC).
- `b` in XLEN: operand B (rs2 / immediate). Shift amount is `b[SHW-1:0]`.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `result` out XLEN: registered result.
- `zero` out 1: `result == 0`, for branch compare.
- `err` out 1: op code was not recognised.

## Operation
- Op codes:
  - ADD=0x00, SUB=0x01, AND=0x02, OR=0x03, XOR=0x04.
  - SLL=0x05, SRL=0x06, SLT=0x07, SRA=0x0E, SLTU=0x0F, SLL_12=0x10.
  - All other codes are illegal.
- FSM states: IDLE, SHIFT, DONE.
- `in_ready` = (state == IDLE).
- Handshake fire: `in_valid & in_ready`. `op`, `a` and `b` are sampled only on fire and may change afterwards.
- IDLE + fire, non-shift op:
  - `result` is computed combinationally and registered; go to DONE.
  - ADD/SUB wrap modulo 2^XLEN.
  - SLT is a signed compare and SLTU is unsigned; both give 1 or 0, zero-extended.
  - SLL_12 gives `b << 12`, the LUI path, done in a single cycle.
  - An illegal op gives `result` = 0, `err` = 1; go to DONE.
- IDLE + fire, SLL/SRL/SRA:
  - Load `acc` = `a`, `cnt` = `b[SHW-1:0]`, and latch the shift kind.
  - If `cnt` == 0, `result` = `a` and go to DONE.
  - Otherwise go to SHIFT.
- SHIFT, each cycle:
  - `acc` shifts by 1: SLL fills with 0, SRL fills with 0, SRA replicates the MSB.
  - `cnt` decrements.
  - When `cnt` == 1 before the decrement, register the shifted value into `result` and go to DONE.
- DONE:
  - `out_valid` = 1.
  - `result`, `zero` and `err` are held stable until `out_valid & out_ready`; then go to IDLE.
  - No new request is accepted in the same cycle as result consumption.
- `zero` and `err` are registered alongside `result`. `err` = 0 for all legal ops.
- Reset, asserted at any time including mid-shift: state = IDLE, `out_valid` = 0, `result` = 0, `zero` = 0, `err` = 0, `acc` = 0, `cnt` = 0. An in-flight operation is discarded.

## Timing
- Latency from fire edge to first `out_valid` cycle:
  - Non-shift ops: 1 cycle.
  - Shifts with amount 0: 1 cycle.
  - Shifts with amount N ≥ 1: 1 + N cycles (maximum 32 for XLEN = 32).
- Throughput: at most one op per 2 cycles (accept, then consume).
- `in_ready` falls in the cycle after fire and rises in the cycle after the consume edge.
- Backpressure: `out_ready` low holds DONE indefinitely with outputs unchanged.
- `in_valid` asserted while `in_ready` is low is ignored; the requester must hold it.

## Structure
- Shared package `alu_pkg` holds:
  - The op-code localparams listed above.
  - The FSM state enum.
  - The instruction-format constants shared with the decoder.
- Sub-module `alu_comb`: purely combinational single-cycle datapath (ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL_12, illegal detect).
- The top level holds the FSM, the shift accumulator and counter, and the output registers.

## Test plan
- ADD: `a` = 5, `b` = 7 → `out_valid` one cycle after fire, `result` = 12, `zero` = 0. SUB: `a` = 3, `b` = 5 → 0xFFFFFFFE.
- SLT with `a` = 0xFFFFFFFF, `b` = 1 → 1. SLTU with the same operands → 0. SUB with `a` = `b` = 0x1234 → `result` = 0, `zero` = 1.
- SRA: `a` = 0x80000000, `b` = 4 → `result` = 0xF8000000 with latency 5. SRL with the same operands → 0x08000000. SLL with `b` = 0 → `a` with latency 1. SLL with `b` = 31, `a` = 1 → 0x80000000 with latency 32.
- SLL_12: `b` = 0x000ABCDE → 0xABCDE000. Illegal op 0x08 → `result` = 0, `err` = 1.
- Backpressure: hold `out_ready` = 0 for 10 cycles → `result` stable and `in_ready` = 0 throughout, while `in_valid` stays high. Release → consume, then accept the held request the following cycle.
- Assert `reset` during the 3rd SHIFT cycle of a 20-bit shift → all outputs 0 immediately, state IDLE. The next ADD executes normally.
